h3_hash_unit: RTL and testbench

Pipelined H3 hash stage that sits directly downstream of `matrix_generator`. Takes the packed per-table hash matrices and a stream of keys, and produces one hash address per table for every accepted key. Uses a valid/ready handshake on both sides and tolerates back-pressure without dropping or duplicating keys. Feeds the table lookup/insert logic of the second-chance hash tables.

---
 rtl/h3_hash_unit_if.sv | 26 ++
 rtl/h3_hash_unit.sv | 102 ++++++++++
 tb/tb_h3_hash_unit.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/h3_hash_unit_if.sv
// Handshake and data bundle between a key source, h3_hash_unit and its consumer.
// The slave modport is the hash unit's view; the master modport drives it.
interface h3_hash_unit_if #(
    parameter int NUMBER_OF_TABLES = 4,
    parameter int HASH_ADR_WIDTH   = 5,
    parameter int KEY_WIDTH        = 6
);
    logic [NUMBER_OF_TABLES*HASH_ADR_WIDTH*KEY_WIDTH-1:0] matrixes_i;
    logic [KEY_WIDTH-1:0]                                 key_i;
    logic                                                 key_valid_i;
    logic                                                 key_ready_o;
    logic [NUMBER_OF_TABLES*HASH_ADR_WIDTH-1:0]           adr_o;
    logic [KEY_WIDTH-1:0]                                 key_o;
    logic                                                 adr_valid_o;
    logic                                                 adr_ready_i;

    modport slave (
        input  matrixes_i, key_i, key_valid_i, adr_ready_i,
        output key_ready_o, adr_o, key_o, adr_valid_o
    );

    modport master (
        output matrixes_i, key_i, key_valid_i, adr_ready_i,
        input  key_ready_o, adr_o, key_o, adr_valid_o
    );
endinterface

// File: rtl/h3_hash_unit.sv
// Pipelined H3 hash: one address per table, adr[i][j] = ^(key & row[i][j]).
// Define H3_HASH_SINGLE_STAGE_EN to drop the AND-product stage (1-cycle latency, capacity 1).
module h3_hash_unit #(
    parameter int NUMBER_OF_TABLES = 4,
    parameter int HASH_ADR_WIDTH   = 5,
    parameter int KEY_WIDTH        = 6
) (
    input  logic          clk,
    input  logic          reset_n,
    h3_hash_unit_if.slave bus
);
    localparam int ROWS = NUMBER_OF_TABLES * HASH_ADR_WIDTH;
    localparam int K    = KEY_WIDTH;

    // Row r = i*A + j lines up with both the matrix packing and the address packing.
    function automatic logic [ROWS*K-1:0] and_rows(input logic [K-1:0] key,
                                                   input logic [ROWS*K-1:0] mat);
        logic [ROWS*K-1:0] prod;
        prod = '0;
        for (int r = 0; r < ROWS; r++) begin
            prod[r*K +: K] = key & mat[r*K +: K];
        end
        return prod;
    endfunction

    function automatic logic [ROWS-1:0] xor_rows(input logic [ROWS*K-1:0] prod);
        logic [ROWS-1:0] adr;
        adr = '0;
        for (int r = 0; r < ROWS; r++) begin
            adr[r] = ^prod[r*K +: K];
        end
        return adr;
    endfunction

    logic            vld_p2;
    logic [ROWS-1:0] adr_p2;
    logic [K-1:0]    key_p2;
    logic            s2_adv;

    assign s2_adv = !vld_p2 || bus.adr_ready_i;

`ifdef H3_HASH_SINGLE_STAGE_EN
    assign bus.key_ready_o = s2_adv;

    // S2: hash computed straight from the input key and current matrix
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_p2 <= 1'b0;
            adr_p2 <= '0;
            key_p2 <= '0;
        end else if (s2_adv) begin
            vld_p2 <= bus.key_valid_i;
            if (bus.key_valid_i) begin
                adr_p2 <= xor_rows(and_rows(bus.key_i, bus.matrixes_i));
                key_p2 <= bus.key_i;
            end
        end
    end
`else
    logic              vld_p1;
    logic [ROWS*K-1:0] and_p1;
    logic [K-1:0]      key_p1;
    logic              s1_adv;

    assign s1_adv          = !vld_p1 || s2_adv;
    assign bus.key_ready_o = s1_adv;

    // S1: AND-products, the matrix is sampled here and travels with the key
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_p1 <= 1'b0;
            and_p1 <= '0;
            key_p1 <= '0;
        end else if (s1_adv) begin
            vld_p1 <= bus.key_valid_i;
            if (bus.key_valid_i) begin
                and_p1 <= and_rows(bus.key_i, bus.matrixes_i);
                key_p1 <= bus.key_i;
            end
        end
    end

    // S2: XOR-reduction; refills from S1 in the same cycle it drains
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_p2 <= 1'b0;
            adr_p2 <= '0;
            key_p2 <= '0;
        end else if (s2_adv) begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                adr_p2 <= xor_rows(and_p1);
                key_p2 <= key_p1;
            end
        end
    end
`endif

    assign bus.adr_valid_o = vld_p2;
    assign bus.adr_o       = adr_p2;
    assign bus.key_o       = key_p2;
endmodule

// File: tb/tb_h3_hash_unit.sv
// Self-checking bench for h3_hash_unit: parity-based reference model with a
// per-cycle scoreboard, plus directed vectors with hand-computed addresses.
module tb_h3_hash_unit;
    localparam int T = 4;
    localparam int A = 5;
    localparam int K = 6;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    h3_hash_unit_if #(.NUMBER_OF_TABLES(T), .HASH_ADR_WIDTH(A), .KEY_WIDTH(K)) bus ();

    h3_hash_unit #(.NUMBER_OF_TABLES(T), .HASH_ADR_WIDTH(A), .KEY_WIDTH(K)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [T*A-1:0] adr;
        logic [K-1:0]   key;
    } exp_t;

    exp_t           q[$];
    int             run = 0;
    int             max_run = 0;
    int             out_count = 0;
    logic           prev_stall = 1'b0;
    logic [T*A-1:0] prev_adr = '0;
    logic [K-1:0]   prev_key = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Address bit = parity of the masked key, table by table.
    function automatic logic [T*A-1:0] model_hash(input logic [K-1:0] k,
                                                  input logic [T*A*K-1:0] m);
        logic [T*A-1:0] r;
        r = '0;
        for (int t = 0; t < T; t++)
            for (int j = 0; j < A; j++)
                r[t*A+j] = ($countones(k & m[(t*A+j)*K +: K]) % 2) == 1;
        return r;
    endfunction

    // Scoreboard: occupancy-based ready, hold-on-stall, in-order outputs.
    always @(negedge clk) begin
        if (!reset_n) begin
            q.delete();
            run = 0;
            prev_stall = 1'b0;
        end else begin
            chk("ready_vs_occupancy", {31'b0, bus.key_ready_o},
                {31'b0, (q.size() < 2) || bus.adr_ready_i});
            if (q.size() == 0) chk("valid_when_empty", {31'b0, bus.adr_valid_o}, 32'd0);
            if (prev_stall) begin
                chk("stall_valid", {31'b0, bus.adr_valid_o}, 32'd1);
                chk("stall_adr", {12'b0, bus.adr_o}, {12'b0, prev_adr});
                chk("stall_key", {26'b0, bus.key_o}, {26'b0, prev_key});
            end
            run = bus.adr_valid_o ? run + 1 : 0;
            if (run > max_run) max_run = run;
            if (bus.adr_valid_o && bus.adr_ready_i) begin
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_output: got key 0x%0h with nothing outstanding at %0t",
                             bus.key_o, $time);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("sb_adr", {12'b0, bus.adr_o}, {12'b0, e.adr});
                    chk("sb_key", {26'b0, bus.key_o}, {26'b0, e.key});
                    out_count++;
                end
            end
            if (bus.key_valid_i && bus.key_ready_o)
                q.push_back('{adr: model_hash(bus.key_i, bus.matrixes_i), key: bus.key_i});
            prev_stall = bus.adr_valid_o && !bus.adr_ready_i;
            prev_adr   = bus.adr_o;
            prev_key   = bus.key_o;
        end
    end

    task automatic set_matrix(input bit t0_on);
        logic [T*A*K-1:0] m;
        m = '0;
        for (int j = 0; j < A; j++) begin
            if (t0_on) m[j*K + j] = 1'b1;
            m[A*K + j*K +: K] = '1;
        end
        bus.matrixes_i = m;
    endtask

    task automatic send(input logic [K-1:0] k);
        int n;
        n = 0;
        bus.key_i = k;
        bus.key_valid_i = 1'b1;
        @(negedge clk);
        while (!bus.key_ready_o && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!bus.key_ready_o) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: key_ready_o stayed 0, required 1");
        end
        @(posedge clk);
        #1 bus.key_valid_i = 1'b0;
    endtask

    task automatic wait_out();
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.adr_valid_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.adr_valid_o) begin
            checks++;
            failures++;
            $display("FAIL wait_out_timeout: adr_valid_o stayed 0, required 1");
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int oc0;
        bus.key_valid_i = 1'b0;
        bus.key_i = '0;
        bus.adr_ready_i = 1'b1;
        set_matrix(1'b1);

        #1;
        chk("rst_valid", {31'b0, bus.adr_valid_o}, 32'd0);
        chk("rst_adr", {12'b0, bus.adr_o}, 32'd0);
        chk("rst_key", {26'b0, bus.key_o}, 32'd0);
        chk("rst_ready", {31'b0, bus.key_ready_o}, 32'd1);

        // Single key, accepted on the first edge after reset release
        @(posedge clk);
        #1 reset_n = 1'b1;
        bus.key_i = 6'b101101;
        bus.key_valid_i = 1'b1;
        @(posedge clk);
        #1 bus.key_valid_i = 1'b0;
        chk("lat_s1_valid", {31'b0, bus.adr_valid_o}, 32'd0);
        @(posedge clk);
        #1;
        chk("lat_s2_valid", {31'b0, bus.adr_valid_o}, 32'd1);
        chk("single_adr", {12'b0, bus.adr_o}, 32'h0000D);
        chk("single_key", {26'b0, bus.key_o}, 32'h2D);
        idle(3);

        // Odd-parity key lights up all of table1
        send(6'b000111);
        wait_out();
        chk("odd_adr", {12'b0, bus.adr_o}, 32'h003E7);
        idle(3);

        // Back-pressure: two keys fill the pipe, the third waits
        bus.adr_ready_i = 1'b0;
        oc0 = out_count;
        bus.key_valid_i = 1'b1;
        bus.key_i = 6'd1;
        @(posedge clk);
        #1 bus.key_i = 6'd2;
        @(posedge clk);
        #1 bus.key_i = 6'd3;
        chk("bp_ready_low", {31'b0, bus.key_ready_o}, 32'd0);
        idle(3);
        chk("bp_ready_still_low", {31'b0, bus.key_ready_o}, 32'd0);
        chk("bp_head_key", {26'b0, bus.key_o}, 32'd1);
        bus.adr_ready_i = 1'b1;
        #1 chk("bp_ready_release", {31'b0, bus.key_ready_o}, 32'd1);
        @(posedge clk);
        #1 bus.key_valid_i = 1'b0;
        idle(5);
        chk("bp_out_count", out_count - oc0, 32'd3);

        // Throughput: 16 back-to-back keys
        oc0 = out_count;
        max_run = 0;
        for (int i = 0; i < 16; i++) send(K'($urandom_range(0, 63)));
        idle(4);
        chk("tp_out_count", out_count - oc0, 32'd16);
        chk("tp_consecutive", {31'b0, max_run >= 16}, 32'd1);

        // Matrix change between two in-flight keys
        send(6'b101101);
        set_matrix(1'b0);
        send(6'b000111);
        wait_out();
        chk("mm_key_a", {12'b0, bus.adr_o}, 32'h0000D);
        @(negedge clk);
        chk("mm_b_valid", {31'b0, bus.adr_valid_o}, 32'd1);
        chk("mm_key_b", {12'b0, bus.adr_o}, 32'h003E0);
        set_matrix(1'b1);
        idle(3);

        // Reset with two keys in flight
        bus.adr_ready_i = 1'b0;
        send(6'd9);
        send(6'd10);
        #2 reset_n = 1'b0;
        #1;
        chk("mid_rst_valid", {31'b0, bus.adr_valid_o}, 32'd0);
        chk("mid_rst_ready", {31'b0, bus.key_ready_o}, 32'd1);
        chk("mid_rst_adr", {12'b0, bus.adr_o}, 32'd0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        bus.adr_ready_i = 1'b1;
        idle(5);
        chk("post_rst_no_stale", {31'b0, bus.adr_valid_o}, 32'd0);
        send(6'b000111);
        wait_out();
        chk("post_rst_adr", {12'b0, bus.adr_o}, 32'h003E7);
        idle(3);

        chk("queue_drained", q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
